// File: rtl/fc_pkg.sv
// Shared constants and helpers for the fully-connected classifier output stage.
package fc_pkg;

   // Active-high segment codes, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Sign-extend the low w bits of v to 32 bits (1 <= w <= 32).
   function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned w);
      logic signed [31:0] t;
      t = signed'(v << (32 - w));
      return t >>> (32 - w);
   endfunction

endpackage

// File: rtl/fc_seg7_enc.sv
// Combinational 7-segment encoder for the class digit ("0"/"1"/blank).
module fc_seg7_enc
   import fc_pkg::*;
#(
   parameter int unsigned ACTIVE_LOW    = 1,
   parameter int unsigned BLANK_ON_IDLE = 1
) (
   input  logic       valid_seen_i,
   input  logic       digit_i,
   output logic [6:0] seg_o
);

   logic [6:0] raw;

   always_comb begin
      raw = SEG_BLANK;
      if (valid_seen_i) begin
         raw = digit_i ? SEG_1 : SEG_0;
      end else if (BLANK_ON_IDLE == 0) begin
         raw = SEG_0;
      end
      seg_o = (ACTIVE_LOW != 0) ? ~raw : raw;
   end

endmodule

// File: rtl/fc_classify_top.sv
// Single-neuron FC output stage: streamed MAC, bias, shift, threshold, 7-seg digit.
// Optional macro FC_ACC_SAT_EN: saturating accumulator and bias add instead of wrap.
// Weights and bias are parameters, generated offline from the weight/bias hex files.
module fc_classify_top
   import fc_pkg::*;
#(
   parameter int unsigned INPUT_NUM     = 3136,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned ACC_BITS      = 26,
   parameter int unsigned SUM_BITS      = 32,
   parameter int unsigned SHIFT_BITS    = 7,
   parameter logic signed [ACC_BITS-1:0] T = '0,
   parameter int unsigned ACTIVE_LOW    = 1,
   parameter int unsigned BLANK_ON_IDLE = 1,
   parameter logic signed [DATA_BITS-1:0] WEIGHTS [INPUT_NUM] = '{default: DATA_BITS'(1)},
   parameter logic signed [SUM_BITS-1:0] BIAS = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 feat_valid,
   input  logic [DATA_BITS-1:0] feat_data,
   output logic [6:0]           seg,
   output logic                 is_one,
   output logic                 sum_valid
);

   localparam int unsigned IDX_BITS = $clog2(INPUT_NUM);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(INPUT_NUM - 1);
   localparam logic [6:0] SEG_IDLE_RAW = (BLANK_ON_IDLE != 0) ? SEG_BLANK : SEG_0;
   localparam logic [6:0] SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_IDLE_RAW : SEG_IDLE_RAW;

   logic [IDX_BITS-1:0]        idx_q, idx_d;
   logic signed [ACC_BITS-1:0] acc_q, acc_d;
   logic                       is_one_q, is_one_d;
   logic                       seen_q, seen_d;
   logic                       sum_valid_q, sum_valid_d;
   logic [6:0]                 seg_q, seg_d;

   logic signed [2*DATA_BITS-1:0] product;
   logic signed [ACC_BITS-1:0]    prod_ext;
   logic signed [ACC_BITS-1:0]    acc_sum;
   logic signed [SUM_BITS-1:0]    final_sum;
   logic signed [SUM_BITS-1:0]    biased;
   logic signed [SUM_BITS-1:0]    scaled;
   logic signed [SUM_BITS-1:0]    thr_ext;
   logic                          above;
   logic                          last;
`ifdef FC_ACC_SAT_EN
   logic signed [ACC_BITS:0]      acc_wide;
   logic signed [SUM_BITS:0]      bias_wide;
`endif

   // Datapath: MAC, bias, shift and compare, all evaluated on the accepted sample.
   always_comb begin
      product  = $signed(feat_data) * WEIGHTS[idx_q];
      prod_ext = ACC_BITS'(sext32(32'(product), 2 * DATA_BITS));
`ifdef FC_ACC_SAT_EN
      acc_wide = {acc_q[ACC_BITS-1], acc_q} + {prod_ext[ACC_BITS-1], prod_ext};
      if (acc_wide[ACC_BITS] != acc_wide[ACC_BITS-1]) begin
         acc_sum = acc_wide[ACC_BITS] ? {1'b1, {(ACC_BITS - 1){1'b0}}}
                                      : {1'b0, {(ACC_BITS - 1){1'b1}}};
      end else begin
         acc_sum = acc_wide[ACC_BITS-1:0];
      end
`else
      acc_sum = acc_q + prod_ext;
`endif
      final_sum = SUM_BITS'(sext32(32'(acc_sum), ACC_BITS));
`ifdef FC_ACC_SAT_EN
      bias_wide = {final_sum[SUM_BITS-1], final_sum} + {BIAS[SUM_BITS-1], BIAS};
      if (bias_wide[SUM_BITS] != bias_wide[SUM_BITS-1]) begin
         biased = bias_wide[SUM_BITS] ? {1'b1, {(SUM_BITS - 1){1'b0}}}
                                      : {1'b0, {(SUM_BITS - 1){1'b1}}};
      end else begin
         biased = bias_wide[SUM_BITS-1:0];
      end
`else
      biased = final_sum + BIAS;
`endif
      scaled  = biased >>> SHIFT_BITS;
      thr_ext = SUM_BITS'(sext32(32'(T), ACC_BITS));
      above   = (scaled > thr_ext);
   end

   // Frame sequencing: the last accepted sample publishes the result and restarts.
   always_comb begin
      last        = feat_valid && (idx_q == LAST_IDX);
      idx_d       = idx_q;
      acc_d       = acc_q;
      is_one_d    = is_one_q;
      seen_d      = seen_q;
      sum_valid_d = 1'b0;
      if (feat_valid) begin
         if (last) begin
            idx_d       = '0;
            acc_d       = '0;
            is_one_d    = above;
            seen_d      = 1'b1;
            sum_valid_d = 1'b1;
         end else begin
            idx_d = idx_q + IDX_BITS'(1);
            acc_d = acc_sum;
         end
      end
   end

   fc_seg7_enc #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .BLANK_ON_IDLE(BLANK_ON_IDLE)
   ) u_seg7_enc (
      .valid_seen_i(seen_d),
      .digit_i     (is_one_d),
      .seg_o       (seg_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         acc_q       <= '0;
         is_one_q    <= 1'b0;
         seen_q      <= 1'b0;
         sum_valid_q <= 1'b0;
         seg_q       <= SEG_IDLE;
      end else begin
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         is_one_q    <= is_one_d;
         seen_q      <= seen_d;
         sum_valid_q <= sum_valid_d;
         seg_q       <= seg_d;
      end
   end

   assign seg       = seg_q;
   assign is_one    = is_one_q;
   assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_fc_classify_top.sv
// Directed self-checking bench for fc_classify_top (weights +1, bias 0, T 0).
module tb_fc_classify_top;

   localparam int N = 3136;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;
   localparam logic [6:0] SEG_BLNK  = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic       feat_valid;
   logic [7:0] feat_data;
   logic [6:0] seg;
   logic       is_one;
   logic       sum_valid;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   logic res_q[$];

   fc_classify_top dut (
      .clk       (clk),
      .rst       (rst),
      .feat_valid(feat_valid),
      .feat_data (feat_data),
      .seg       (seg),
      .is_one    (is_one),
      .sum_valid (sum_valid)
   );

   always #5 clk = ~clk;

   // Pulse counter and per-pulse class log.
   always @(posedge clk) begin
      if (sum_valid === 1'b1) begin
         pulses <= pulses + 1;
         res_q.push_back(is_one);
      end
   end

   task automatic send(input logic [7:0] x);
      @(negedge clk);
      feat_valid = 1'b1;
      feat_data  = x;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      feat_valid = 1'b0;
      feat_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (is_one !== 1'b0) begin errors++;
         $display("FAIL reset_is_one: got %b want 0", is_one); end
      checks++; if (sum_valid !== 1'b0) begin errors++;
         $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
      checks++; if (seg !== SEG_BLNK) begin errors++;
         $display("FAIL reset_seg: got %b want %b", seg, SEG_BLNK); end
      checks++; if (pulses !== 0) begin errors++;
         $display("FAIL reset_pulses: got %0d want 0", pulses); end
   endtask

   task automatic test_ones();
      int p0 = pulses;
      for (int k = 0; k < N; k++) send(8'h01);
      @(negedge clk);
      feat_valid = 1'b0;
      checks++; if (sum_valid !== 1'b1) begin errors++;
         $display("FAIL ones_pulse: got %b want 1", sum_valid); end
      checks++; if (is_one !== 1'b1) begin errors++;
         $display("FAIL ones_is_one: got %b want 1", is_one); end
      checks++; if (seg !== SEG_ONE) begin errors++;
         $display("FAIL ones_seg: got %b want %b", seg, SEG_ONE); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (sum_valid !== 1'b0) begin errors++;
            $display("FAIL ones_quiet%0d: got %b want 0", c, sum_valid); end
      end
      checks++; if (pulses !== p0 + 1) begin errors++;
         $display("FAIL ones_count: got %0d want %0d", pulses, p0 + 1); end
   endtask

   task automatic test_zeros();
      int p0 = pulses;
      for (int k = 0; k < N; k++) send(8'h00);
      @(negedge clk);
      feat_valid = 1'b0;
      checks++; if (sum_valid !== 1'b1) begin errors++;
         $display("FAIL zeros_pulse: got %b want 1", sum_valid); end
      checks++; if (is_one !== 1'b0) begin errors++;
         $display("FAIL zeros_is_one: got %b want 0", is_one); end
      checks++; if (seg !== SEG_ZERO) begin errors++;
         $display("FAIL zeros_seg: got %b want %b", seg, SEG_ZERO); end
      repeat (3) @(negedge clk);
      checks++; if (pulses !== p0 + 1) begin errors++;
         $display("FAIL zeros_count: got %0d want %0d", pulses, p0 + 1); end
   endtask

   task automatic test_gaps();
      int p0 = pulses;
      for (int k = 0; k < N; k++) begin
         if (k != 0 && (k % 100) == 0) begin
            repeat (5) begin
               @(negedge clk);
               feat_valid = 1'b0;
               feat_data  = 8'h01;
            end
         end
         if (k == N - 1) begin
            checks++; if (pulses !== p0) begin errors++;
               $display("FAIL gaps_early: got %0d pulses want %0d", pulses, p0); end
         end
         send(8'hFF);
      end
      @(negedge clk);
      feat_valid = 1'b0;
      checks++; if (sum_valid !== 1'b1) begin errors++;
         $display("FAIL gaps_pulse: got %b want 1", sum_valid); end
      checks++; if (is_one !== 1'b0) begin errors++;
         $display("FAIL gaps_is_one: got %b want 0", is_one); end
      checks++; if (seg !== SEG_ZERO) begin errors++;
         $display("FAIL gaps_seg: got %b want %b", seg, SEG_ZERO); end
      repeat (3) @(negedge clk);
      checks++; if (pulses !== p0 + 1) begin errors++;
         $display("FAIL gaps_count: got %0d want %0d", pulses, p0 + 1); end
   endtask

   task automatic test_back_to_back();
      int va[N];
      int vb[N];
      int sa = 0;
      int sb = 0;
      logic exp_a, exp_b;
      int p0 = pulses;
      int r0 = res_q.size();
      for (int k = 0; k < N; k++) begin
         va[k] = int'($urandom_range(0, 160)) - 60;
         vb[k] = int'($urandom_range(0, 160)) - 100;
         sa += va[k];
         sb += vb[k];
      end
      exp_a = ((sa >>> 7) > 0);
      exp_b = ((sb >>> 7) > 0);
      for (int k = 0; k < N; k++) send(8'(va[k]));
      for (int k = 0; k < N; k++) send(8'(vb[k]));
      @(negedge clk);
      feat_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (pulses !== p0 + 2) begin errors++;
         $display("FAIL b2b_count: got %0d want %0d", pulses, p0 + 2); end
      if (res_q.size() >= r0 + 2) begin
         checks++; if (res_q[r0] !== exp_a) begin errors++;
            $display("FAIL b2b_frame_a: got %b want %b (sum %0d)", res_q[r0], exp_a, sa); end
         checks++; if (res_q[r0+1] !== exp_b) begin errors++;
            $display("FAIL b2b_frame_b: got %b want %b (sum %0d)", res_q[r0+1], exp_b, sb); end
      end else begin
         checks++; errors++;
         $display("FAIL b2b_results: got %0d results want 2", res_q.size() - r0);
      end
      checks++; if (is_one !== exp_b) begin errors++;
         $display("FAIL b2b_hold: got %b want %b", is_one, exp_b); end
   endtask

   task automatic test_reset_mid();
      int p0 = pulses;
      for (int k = 0; k < 1000; k++) send(8'h01);
      @(negedge clk);
      feat_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (seg !== SEG_BLNK) begin errors++;
         $display("FAIL rstmid_seg: got %b want %b", seg, SEG_BLNK); end
      checks++; if (pulses !== p0) begin errors++;
         $display("FAIL rstmid_no_pulse: got %0d want %0d", pulses, p0); end
      for (int k = 0; k < N; k++) send(8'h00);
      @(negedge clk);
      feat_valid = 1'b0;
      checks++; if (sum_valid !== 1'b1) begin errors++;
         $display("FAIL rstmid_pulse: got %b want 1", sum_valid); end
      checks++; if (is_one !== 1'b0) begin errors++;
         $display("FAIL rstmid_is_one: got %b want 0", is_one); end
      checks++; if (seg !== SEG_ZERO) begin errors++;
         $display("FAIL rstmid_seg_zero: got %b want %b", seg, SEG_ZERO); end
      repeat (3) @(negedge clk);
      checks++; if (pulses !== p0 + 1) begin errors++;
         $display("FAIL rstmid_count: got %0d want %0d", pulses, p0 + 1); end
   endtask

   initial begin
      rst        = 1'b1;
      feat_valid = 1'b0;
      feat_data  = 8'h00;
      test_reset();
      test_ones();
      test_zeros();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
